row_drain_serializer: RTL and testbench

Captures one row of N_INPUTS results produced in parallel by the systolic array's edge PEs and streams them out one element per beat over a valid/ready interface. It owns the select counter and drives an internal `mux` instance to pick the current element, so it sits between the array's result edge and the serial result writer.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/row_drain_serializer_if.sv | 34 +++
 rtl/mux.sv | 26 ++
 rtl/row_drain_serializer.sv | 73 +++++++
 tb/tb_row_drain_serializer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_pkg : shared types and default sizes for the systolic array edge.
// Rev 1.0
// ---------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [0:0] {
    DRAIN_IDLE   = 1'b0,
    DRAIN_ACTIVE = 1'b1
  } drain_state_t;

  localparam int DEFAULT_DATAWIDTH = 16;
  localparam int DEFAULT_N_INPUTS  = 8;
  localparam int DEFAULT_SELWIDTH  = 3;

endpackage
`default_nettype wire

// File: rtl/row_drain_serializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// row_drain_serializer_if : parallel row in, serial element stream out.
// Rev 1.0
// ---------------------------------------------------------------------------
interface row_drain_serializer_if
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_INPUTS  = DEFAULT_N_INPUTS,
  parameter int SELWIDTH  = DEFAULT_SELWIDTH
);
  logic                               in_valid;
  logic                               in_ready;
  logic [N_INPUTS-1:0][DATAWIDTH-1:0] in_array;
  logic                               out_valid;
  logic                               out_ready;
  logic [DATAWIDTH-1:0]               out_data;
  logic [SELWIDTH-1:0]                out_index;
  logic                               out_last;
  logic                               busy;

  // master: the side that produces rows and consumes elements
  modport master (
    output in_valid, in_array, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_array, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux : selects one element of a packed row; out-of-range selects give zero.
// Rev 1.0
// ---------------------------------------------------------------------------
module mux
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_INPUTS  = DEFAULT_N_INPUTS,
  parameter int SELWIDTH  = DEFAULT_SELWIDTH
) (
  input  wire logic [N_INPUTS-1:0][DATAWIDTH-1:0] in_array,
  input  wire logic [SELWIDTH-1:0]                sel,
  output logic      [DATAWIDTH-1:0]               out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel == SELWIDTH'(i)) out = in_array[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/row_drain_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// row_drain_serializer : captures a parallel row and drains it one element
// per valid/ready beat, chaining rows without a bubble.  Rev 1.0
// ---------------------------------------------------------------------------
module row_drain_serializer
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_INPUTS  = DEFAULT_N_INPUTS,
  parameter int SELWIDTH  = DEFAULT_SELWIDTH
) (
  input wire logic              clk,
  input wire logic              rst,
  row_drain_serializer_if.slave bus
);

  localparam logic [SELWIDTH-1:0] c_LAST_SEL = SELWIDTH'(N_INPUTS - 1);

  drain_state_t                       r_state;
  logic [SELWIDTH-1:0]                r_sel;
  logic [N_INPUTS-1:0][DATAWIDTH-1:0] r_bank;

  logic                               w_active;
  logic                               w_last;
  logic                               w_in_fire;
  logic                               w_out_fire;
  logic [DATAWIDTH-1:0]               w_data;

  assign w_active   = (r_state == DRAIN_ACTIVE);
  assign w_last     = w_active && (r_sel == c_LAST_SEL);
  assign w_out_fire = w_active && bus.out_ready;
  assign w_in_fire  = bus.in_ready && bus.in_valid;

  // Ready for a new row while idle, or on the beat that retires the last element.
  assign bus.in_ready  = !rst && (!w_active || (w_last && bus.out_ready));
  assign bus.out_valid = w_active;
  assign bus.busy      = w_active;
  assign bus.out_index = r_sel;
  assign bus.out_last  = w_last;
  assign bus.out_data  = w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DRAIN_IDLE;
      r_sel   <= '0;
      r_bank  <= '0;
    end else if (w_in_fire) begin
      r_state <= DRAIN_ACTIVE;
      r_sel   <= '0;
      r_bank  <= bus.in_array;
    end else if (w_out_fire) begin
      if (w_last) begin
        r_state <= DRAIN_IDLE;
        r_sel   <= '0;
      end else begin
        r_sel   <= r_sel + SELWIDTH'(1);
      end
    end
  end

  mux #(
    .DATAWIDTH (DATAWIDTH),
    .N_INPUTS  (N_INPUTS),
    .SELWIDTH  (SELWIDTH)
  ) u_mux (
    .in_array (r_bank),
    .sel      (r_sel),
    .out      (w_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_row_drain_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_row_drain_serializer : random and directed stimulus on an 8-wide and a
// 5-wide instance, checked every cycle against a row-queue model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_row_drain_serializer;

  localparam int W  = 16;
  localparam int NA = 8;
  localparam int NB = 5;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  logic started  = 1'b0;
  logic rst_done = 1'b0;
  logic done     = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  row_drain_serializer_if #(.DATAWIDTH(W), .N_INPUTS(NA), .SELWIDTH(SW)) a_if ();
  row_drain_serializer_if #(.DATAWIDTH(W), .N_INPUTS(NB), .SELWIDTH(SW)) b_if ();

  row_drain_serializer #(.DATAWIDTH(W), .N_INPUTS(NA), .SELWIDTH(SW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  row_drain_serializer #(.DATAWIDTH(W), .N_INPUTS(NB), .SELWIDTH(SW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: the remaining elements of the row being drained, in order.
  int qa_d[$];
  int qa_i[$];
  int log_a[$];
  int qb_d[$];
  int qb_i[$];
  int log_b[$];

  always @(negedge clk) begin
    bit ne;
    bit rdy;
    if (started) begin
      ne  = (qa_d.size() != 0);
      rdy = !rst && (!ne || (qa_d.size() == 1 && a_if.out_ready));
      chk("a_in_ready",  32'(a_if.in_ready),  32'(rdy));
      chk("a_out_valid", 32'(a_if.out_valid), 32'(ne));
      chk("a_busy",      32'(a_if.busy),      32'(ne));
      chk("a_out_index", 32'(a_if.out_index), ne ? qa_i[0] : 0);
      chk("a_out_last",  32'(a_if.out_last),  ne ? 32'(qa_i[0] == NA-1) : 0);
      if (ne) chk("a_out_data", 32'(a_if.out_data), qa_d[0]);
      if (rst) begin
        qa_d.delete();
        qa_i.delete();
      end else begin
        if (ne && a_if.out_ready) begin
          log_a.push_back(qa_d[0]);
          void'(qa_d.pop_front());
          void'(qa_i.pop_front());
        end
        if (rdy && a_if.in_valid) begin
          for (int i = 0; i < NA; i++) begin
            qa_d.push_back(int'(a_if.in_array[i]));
            qa_i.push_back(i);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ne;
    bit rdy;
    if (started) begin
      ne  = (qb_d.size() != 0);
      rdy = !rst && (!ne || (qb_d.size() == 1 && b_if.out_ready));
      chk("b_in_ready",  32'(b_if.in_ready),  32'(rdy));
      chk("b_out_valid", 32'(b_if.out_valid), 32'(ne));
      chk("b_busy",      32'(b_if.busy),      32'(ne));
      chk("b_out_index", 32'(b_if.out_index), ne ? qb_i[0] : 0);
      chk("b_out_last",  32'(b_if.out_last),  ne ? 32'(qb_i[0] == NB-1) : 0);
      if (ne) chk("b_out_data", 32'(b_if.out_data), qb_d[0]);
      if (rst) begin
        qb_d.delete();
        qb_i.delete();
      end else begin
        if (ne && b_if.out_ready) begin
          log_b.push_back(qb_i[0]);
          void'(qb_d.pop_front());
          void'(qb_i.pop_front());
        end
        if (rdy && b_if.in_valid) begin
          for (int i = 0; i < NB; i++) begin
            qb_d.push_back(int'(b_if.in_array[i]));
            qb_i.push_back(i);
          end
        end
      end
    end
  end

  task automatic rand_row_a;
    for (int i = 0; i < NA; i++) a_if.in_array[i] = W'($urandom);
  endtask

  // Odd-size instance: one directed row, then random traffic until the end.
  initial begin
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b0;
    b_if.in_array  = '0;
    wait (rst_done);
    tick;
    log_b.delete();
    for (int i = 0; i < NB; i++) b_if.in_array[i] = W'(100 + i);
    b_if.in_valid  = 1'b1;
    b_if.out_ready = 1'b1;
    tick;
    b_if.in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk("b_odd_index", 32'(b_if.out_index), k);
      chk("b_odd_last",  32'(b_if.out_last),  32'(k == NB-1));
      chk("b_odd_data",  32'(b_if.out_data),  100 + k);
      tick;
    end
    chk("b_odd_idle", 32'(b_if.out_valid), 0);
    chk("b_odd_count", log_b.size(), NB);
    while (!done) begin
      b_if.in_valid  = 1'($urandom);
      b_if.out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < NB; i++) b_if.in_array[i] = W'($urandom);
      tick;
    end
    b_if.in_valid = 1'b0;
  end

  initial begin
    logic [NA-1:0][W-1:0] ra;
    logic [NA-1:0][W-1:0] rb;
    int cyc;

    rst            = 1'b1;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b0;
    a_if.in_array  = '0;
    @(posedge clk);
    #1;
    started = 1'b1;
    chk("rst_out_valid", 32'(a_if.out_valid), 0);
    chk("rst_out_data",  32'(a_if.out_data),  0);
    chk("rst_out_index", 32'(a_if.out_index), 0);
    chk("rst_busy",      32'(a_if.busy),      0);
    chk("rst_in_ready",  32'(a_if.in_ready),  0);
    tick;
    rst = 1'b0;
    tick;
    rst_done = 1'b1;
    chk("idle_in_ready", 32'(a_if.in_ready), 1);

    // Single row, element i = 10*i, no stall.
    log_a.delete();
    for (int i = 0; i < NA; i++) a_if.in_array[i] = W'(10 * i);
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b1;
    tick;
    a_if.in_valid = 1'b0;
    chk("t1_first_valid", 32'(a_if.out_valid), 1);
    repeat (NA) tick;
    chk("t1_count", log_a.size(), NA);
    for (int i = 0; i < log_a.size() && i < NA; i++) chk("t1_data", log_a[i], 10 * i);
    chk("t1_end_valid", 32'(a_if.out_valid), 0);
    chk("t1_end_ready", 32'(a_if.in_ready),  1);

    // Backpressure with out_ready pattern 1,0,0,1,...
    log_a.delete();
    rand_row_a();
    ra = a_if.in_array;
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b0;
    tick;
    a_if.in_valid = 1'b0;
    cyc = 0;
    while (qa_d.size() != 0 && cyc < 100) begin
      a_if.out_ready = (cyc % 3) == 0;
      rand_row_a();
      tick;
      cyc++;
    end
    chk("bp_drained", qa_d.size(), 0);
    chk("bp_handshakes", log_a.size(), NA);
    for (int i = 0; i < log_a.size() && i < NA; i++) chk("bp_data", log_a[i], int'(ra[i]));

    // Back-to-back rows: B presented during A's last beat.
    log_a.delete();
    rand_row_a();
    ra = a_if.in_array;
    rand_row_a();
    rb = a_if.in_array;
    a_if.in_array  = ra;
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b1;
    tick;
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 2 * NA; k++) begin
      if (k == NA - 1) begin
        a_if.in_array = rb;
        a_if.in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(a_if.in_ready), 1);
      end
      chk("b2b_no_gap", 32'(a_if.out_valid), 1);
      tick;
      a_if.in_valid = 1'b0;
      rand_row_a();
    end
    chk("b2b_end_valid", 32'(a_if.out_valid), 0);
    chk("b2b_count", log_a.size(), 2 * NA);
    for (int i = 0; i < log_a.size() && i < 2 * NA; i++)
      chk("b2b_data", log_a[i], (i < NA) ? int'(ra[i]) : int'(rb[i - NA]));

    // Reset mid-drain after 3 handshakes, with a competing in_valid.
    log_a.delete();
    rand_row_a();
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b1;
    tick;
    a_if.in_valid = 1'b0;
    repeat (3) tick;
    chk("mid_index_before", 32'(a_if.out_index), 3);
    rst = 1'b1;
    a_if.in_valid = 1'b1;
    tick;
    rst = 1'b0;
    a_if.in_valid = 1'b0;
    chk("mid_out_valid", 32'(a_if.out_valid), 0);
    chk("mid_out_index", 32'(a_if.out_index), 0);
    chk("mid_busy",      32'(a_if.busy),      0);
    tick;
    chk("mid_not_captured", 32'(a_if.out_valid), 0);
    log_a.delete();
    rand_row_a();
    a_if.in_valid = 1'b1;
    tick;
    a_if.in_valid = 1'b0;
    chk("mid_restart_index", 32'(a_if.out_index), 0);
    repeat (NA) tick;
    chk("mid_restart_count", log_a.size(), NA);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom % 64) == 0;
      a_if.in_valid  = 1'($urandom);
      a_if.out_ready = ($urandom % 4) != 0;
      rand_row_a();
      tick;
    end
    rst            = 1'b0;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    done = 1'b1;
    b_if.out_ready = 1'b1;
    repeat (12) tick;
    chk("final_a_idle", 32'(a_if.out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
